avalon_mm_ddr_responder: RTL and testbench
==========================================

Name: avalon_mm_ddr_responder

Overview:
- Avalon-MM agent (responder) that emulates the DDR controller port `amm_*_0` driven by the team's Avalon-MM DDR host.
- Backs the port with on-chip RAM and supports single and burst reads and writes, byte enables, and a fixed read latency.
- Used in simulation and in loopback builds as a stand-in for the external memory controller.

Parameters:
- ADDR_W, 25, word address width.
- DATA_W, 256, data width.
- BE_W, 32, byte-enable width; must equal DATA_W/8.
- MEM_AW, 10, log2 of RAM depth in words. The RAM is indexed by address[MEM_AW-1:0]; upper address bits are ignored, so addresses alias.
- RD_LATENCY, 4, cycles from beat issue to readdatavalid; minimum 1.
- BURST_W, 7, burstcount width.

Ports:
- CLK_I  in  1  clock.
- RST_I  in  1  synchronous active-high reset.
- amm_address_0  in  ADDR_W  word address; sampled only on the command cycle.
- amm_read_0  in  1  read request.
- amm_write_0  in  1  write request.
- amm_writedata_0  in  DATA_W  write data.
- amm_byteenable_0  in  BE_W  per-byte write mask.
- amm_burstcount_0  in  BURST_W  beats per command; 0 is treated as 1.
- amm_ready_0  out  1  agent can accept (inverse waitrequest).
- amm_readdata_0  out  DATA_W  read data.
- amm_readdatavalid_0  out  1  amm_readdata_0 is valid this cycle.
- wr_beat_cnt  out  32  total write beats accepted; wraps.
- rd_beat_cnt  out  32  total read beats returned; wraps.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (RST_I high at a clock edge):
  - state=IDLE; amm_ready_0=1; amm_readdatavalid_0=0; amm_readdata_0=0.
  - Counters = 0; proto_err=0.
  - All read-pipeline valid bits cleared, so in-flight reads are dropped.
  - RAM contents are not cleared.
- Transfer accept: a beat transfers only on a cycle where amm_ready_0=1 and the request is high.
- States:
  - IDLE. Write command (write & ready):
    - Latch addr and beats = max(burstcount,1).
    - Write beat 0 at addr.
    - If beats>1, go to WR_BURST with beat_idx=1.
  - IDLE. Read command (read & ready, write low):
    - Latch addr and beats.
    - Issue beat 0 into the latency pipeline.
    - If beats>1, go to RD_BURST with beat_idx=1.
  - WR_BURST:
    - amm_ready_0=1.
    - Each accepted beat writes to addr+beat_idx, then beat_idx++. Idle cycles (write low) are allowed.
    - After the last beat, go to IDLE.
    - amm_address_0 and amm_burstcount_0 are ignored.
  - RD_BURST:
    - amm_ready_0=0.
    - One beat issued per cycle at addr+beat_idx.
    - After issuing the last beat, go to IDLE; ready returns to 1 on the next cycle.
- Write data path: byte i of the RAM word is updated only if byteenable[i]=1.
- Address arithmetic: addr+beat_idx is computed modulo 2^MEM_AW and wraps from top of RAM to 0.
- Read latency:
  - A beat issued in cycle t yields readdatavalid=1 in cycle t+RD_LATENCY.
  - The pipeline holds up to RD_LATENCY beats, so back-to-back read commands are accepted without bubbles.
- Data outside valid cycles: amm_readdata_0 holds its last value when readdatavalid=0.
- Ordering: a write accepted in cycle t is visible to a read beat issued in cycle t+1 or later.
- Simultaneous read & write in IDLE:
  - The write is serviced and the read is ignored.
  - proto_err is set.
- amm_read_0 high during WR_BURST: the read is ignored and proto_err is set.
- Write counting: wr_beat_cnt increments once per accepted write beat.
- Read counting: rd_beat_cnt increments on every readdatavalid cycle.
- Reset mid-burst: takes effect at the next edge; the remaining beats are abandoned.

Optional Feature:
- Macro: AMM_RESP_RANDOM_WAIT_EN.
- When defined:
  - A 16-bit LFSR, x^16+x^14+x^13+x^11+1, seeded to 16'hACE1 on reset, advances every cycle.
  - amm_ready_0 is additionally forced to 0 in IDLE and WR_BURST on cycles where lfsr[1:0]==2'b00.
  - Beats not accepted on those cycles must be held by the host.
- When undefined: no LFSR exists and ready follows the state rules only.

Test Plan:
- Reset sequence: hold RST_I high for 2 cycles, then release -> ready=1, readdatavalid=0, wr_beat_cnt=0, rd_beat_cnt=0, proto_err=0.
- Single write then single read:
  - Write addr 0x10, data 0xA5..A5, be all ones; next cycle read addr 0x10, burstcount 1.
  - readdatavalid=1 exactly 4 cycles after the read accept, data 0xA5..A5.
- Byte-enable masking:
  - Write 0 to addr 3 with be=FFFFFFFF; then write all ones with be=0000000F; then read addr 3.
  - Read data has low 32 bits all ones, rest zero.
- Write burst across the RAM top:
  - Burstcount 4 at addr 0x3FE, data 1..4, with write deasserted for 2 cycles mid-burst.
  - Read burst 4 at 0x3FE returns 1,2,3,4 on consecutive cycles.
  - ready=0 for 3 cycles after the read accept; wr_beat_cnt=4, rd_beat_cnt=4.
- Protocol violation:
  - read & write together in IDLE at addr 5 -> write performed, no readdatavalid, proto_err=1.
  - proto_err stays 1 until reset.
- Reset mid-read: reset 2 cycles after a burst-8 read accept -> no readdatavalid after reset, state IDLE, ready=1.

Source files
------------

// File: rtl/avalon_mm_ddr_responder_if.sv
// ---------------------------------------------------------------------------
// avalon_mm_ddr_responder_if
// Avalon-MM bundle for the emulated DDR controller port (amm_*_0).
//   master modport : host side; drives command/write data, receives ready
//                    and read return.
//   slave  modport : responder side; the mirror of master.
// Signals:
//   amm_address_0       word address
//   amm_read_0          read request
//   amm_write_0         write request
//   amm_writedata_0     write data
//   amm_byteenable_0    per-byte write mask
//   amm_burstcount_0    beats per command (0 means 1)
//   amm_ready_0         responder can accept (inverse waitrequest)
//   amm_readdata_0      read data
//   amm_readdatavalid_0 read data valid
// ---------------------------------------------------------------------------
interface avalon_mm_ddr_responder_if #(
  parameter int ADDR_W  = 25,
  parameter int DATA_W  = 256,
  parameter int BE_W    = 32,
  parameter int BURST_W = 7
);
  logic [ADDR_W-1:0]  amm_address_0;
  logic               amm_read_0;
  logic               amm_write_0;
  logic [DATA_W-1:0]  amm_writedata_0;
  logic [BE_W-1:0]    amm_byteenable_0;
  logic [BURST_W-1:0] amm_burstcount_0;
  logic               amm_ready_0;
  logic [DATA_W-1:0]  amm_readdata_0;
  logic               amm_readdatavalid_0;

  modport master (
    output amm_address_0, amm_read_0, amm_write_0, amm_writedata_0,
           amm_byteenable_0, amm_burstcount_0,
    input  amm_ready_0, amm_readdata_0, amm_readdatavalid_0
  );

  modport slave (
    input  amm_address_0, amm_read_0, amm_write_0, amm_writedata_0,
           amm_byteenable_0, amm_burstcount_0,
    output amm_ready_0, amm_readdata_0, amm_readdatavalid_0
  );
endinterface

// File: rtl/avalon_mm_ddr_responder.sv
// ---------------------------------------------------------------------------
// avalon_mm_ddr_responder
// On-chip-RAM stand-in for the external DDR controller port. Accepts single
// and burst reads/writes with byte enables; read data returns a fixed
// RD_LATENCY cycles after each beat is issued.
// Ports:
//   CLK_I        clock
//   RST_I        synchronous active-high reset
//   amm          Avalon-MM slave modport (see avalon_mm_ddr_responder_if)
//   wr_beat_cnt  accepted write beats (wraps)
//   rd_beat_cnt  returned read beats (wraps)
//   proto_err    sticky: read+write together in IDLE, or read during a
//                write burst
// Optional feature macro: AMM_RESP_RANDOM_WAIT_EN
//   Adds a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) that drops
//   ready in IDLE/WR_BURST whenever lfsr[1:0]==2'b00.
// ---------------------------------------------------------------------------
module avalon_mm_ddr_responder #(
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 256,
  parameter int BE_W       = 32,
  parameter int MEM_AW     = 10,
  parameter int RD_LATENCY = 4,
  parameter int BURST_W    = 7
) (
  input  logic                      CLK_I,
  input  logic                      RST_I,
  avalon_mm_ddr_responder_if.slave  amm,
  output logic [31:0]               wr_beat_cnt,
  output logic [31:0]               rd_beat_cnt,
  output logic                      proto_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [MEM_AW-1:0]  addr_q, addr_d;
  logic [BURST_W-1:0] beats_q, beats_d;
  logic [BURST_W-1:0] idx_q, idx_d;
  logic               ready_q, ready_d;
  logic [31:0]        wr_cnt_q, rd_cnt_q;
  logic               perr_q;

  logic               wr_en_s, rd_issue_s, perr_s;
  logic [MEM_AW-1:0]  wr_addr_s, rd_addr_s, burst_addr_s, cmd_addr_s;
  logic [BURST_W-1:0] beats_cmd_s;
  logic               last_beat_s;
  logic               unused_addr_s;

  logic [DATA_W-1:0]     mem_q [0:(1<<MEM_AW)-1];
  logic [RD_LATENCY-1:0] pv_q;
  logic [DATA_W-1:0]     pd_q [RD_LATENCY];

`ifdef AMM_RESP_RANDOM_WAIT_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
`endif

  // Upper address bits alias onto the RAM and are intentionally dropped.
  assign unused_addr_s = ^amm.amm_address_0[ADDR_W-1:MEM_AW];
  assign cmd_addr_s    = amm.amm_address_0[MEM_AW-1:0];
  assign beats_cmd_s   = (amm.amm_burstcount_0 == {BURST_W{1'b0}}) ?
                         BURST_W'(1) : amm.amm_burstcount_0;
  // Truncation to MEM_AW bits gives the top-of-RAM wrap for free.
  assign burst_addr_s  = addr_q + MEM_AW'(idx_q);
  assign last_beat_s   = (idx_q == BURST_W'(beats_q - BURST_W'(1)));

  // Next-state, beat issue and protocol-check decode.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beats_d    = beats_q;
    idx_d      = idx_q;
    wr_en_s    = 1'b0;
    rd_issue_s = 1'b0;
    perr_s     = 1'b0;
    wr_addr_s  = burst_addr_s;
    rd_addr_s  = burst_addr_s;
    case (state_q)
      IDLE: begin
        wr_addr_s = cmd_addr_s;
        rd_addr_s = cmd_addr_s;
        perr_s    = amm.amm_read_0 & amm.amm_write_0;
        if (ready_q && amm.amm_write_0) begin
          wr_en_s = 1'b1;
          addr_d  = cmd_addr_s;
          beats_d = beats_cmd_s;
          idx_d   = BURST_W'(1);
          state_d = (beats_cmd_s > BURST_W'(1)) ? WR_BURST : IDLE;
        end else if (ready_q && amm.amm_read_0) begin
          rd_issue_s = 1'b1;
          addr_d     = cmd_addr_s;
          beats_d    = beats_cmd_s;
          idx_d      = BURST_W'(1);
          state_d    = (beats_cmd_s > BURST_W'(1)) ? RD_BURST : IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      WR_BURST: begin
        perr_s = amm.amm_read_0;
        if (ready_q && amm.amm_write_0) begin
          wr_en_s = 1'b1;
          idx_d   = idx_q + BURST_W'(1);
          state_d = last_beat_s ? IDLE : WR_BURST;
        end else begin
          state_d = WR_BURST;
        end
      end
      RD_BURST: begin
        rd_issue_s = 1'b1;
        idx_d      = idx_q + BURST_W'(1);
        state_d    = last_beat_s ? IDLE : RD_BURST;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef AMM_RESP_RANDOM_WAIT_EN
    ready_d = (state_d != RD_BURST) && (lfsr_d[1:0] != 2'b00);
`else
    ready_d = (state_d != RD_BURST);
`endif
  end

  // Control state, registered ready, counters and sticky error flag.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q  <= IDLE;
      addr_q   <= {MEM_AW{1'b0}};
      beats_q  <= {BURST_W{1'b0}};
      idx_q    <= {BURST_W{1'b0}};
      ready_q  <= 1'b1;
      wr_cnt_q <= 32'd0;
      rd_cnt_q <= 32'd0;
      perr_q   <= 1'b0;
`ifdef AMM_RESP_RANDOM_WAIT_EN
      lfsr_q   <= 16'hACE1;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      beats_q  <= beats_d;
      idx_q    <= idx_d;
      ready_q  <= ready_d;
      wr_cnt_q <= wr_cnt_q + {31'd0, wr_en_s};
      rd_cnt_q <= rd_cnt_q + {31'd0, pv_q[RD_LATENCY-1]};
      perr_q   <= perr_q | perr_s;
`ifdef AMM_RESP_RANDOM_WAIT_EN
      lfsr_q   <= lfsr_d;
`endif
    end
  end

  // Byte-masked RAM write; contents survive reset.
  always_ff @(posedge CLK_I) begin
    if (wr_en_s) begin
      for (int i = 0; i < BE_W; i++) begin
        if (amm.amm_byteenable_0[i]) begin
          mem_q[wr_addr_s][8*i +: 8] <= amm.amm_writedata_0[8*i +: 8];
        end
      end
    end
  end

  // Read latency pipeline; the last stage is the output register, and its
  // data only moves with a valid beat so readdata holds between returns.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      pv_q <= {RD_LATENCY{1'b0}};
      for (int k = 0; k < RD_LATENCY; k++) begin
        pd_q[k] <= {DATA_W{1'b0}};
      end
    end else begin
      pv_q[0] <= rd_issue_s;
      if (rd_issue_s) begin
        pd_q[0] <= mem_q[rd_addr_s];
      end
      for (int k = 1; k < RD_LATENCY; k++) begin
        pv_q[k] <= pv_q[k-1];
        if (pv_q[k-1]) begin
          pd_q[k] <= pd_q[k-1];
        end
      end
    end
  end

  assign amm.amm_ready_0         = ready_q;
  assign amm.amm_readdatavalid_0 = pv_q[RD_LATENCY-1];
  assign amm.amm_readdata_0      = pd_q[RD_LATENCY-1];
  assign wr_beat_cnt             = wr_cnt_q;
  assign rd_beat_cnt             = rd_cnt_q;
  assign proto_err               = perr_q;

endmodule

// File: tb/tb_avalon_mm_ddr_responder.sv
// ---------------------------------------------------------------------------
// tb_avalon_mm_ddr_responder
// Directed stimulus with a scoreboard: each issued read beat pushes its
// expected data and return cycle; a negedge monitor pops and compares on
// every readdatavalid.
// ---------------------------------------------------------------------------
module tb_avalon_mm_ddr_responder;
  localparam int LAT = 4;

  typedef struct {
    logic [255:0] d;
    int           c;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] wr_beat_cnt, rd_beat_cnt;
  logic        proto_err;
  int          cyc;
  int          n_tests;
  int          n_fail;
  exp_t        sb[$];
  exp_t        mon_e;

  avalon_mm_ddr_responder_if #(.ADDR_W(25), .DATA_W(256), .BE_W(32), .BURST_W(7)) amm ();

  avalon_mm_ddr_responder #(
    .ADDR_W(25), .DATA_W(256), .BE_W(32), .MEM_AW(10), .RD_LATENCY(LAT), .BURST_W(7)
  ) dut (
    .CLK_I       (clk),
    .RST_I       (rst),
    .amm         (amm),
    .wr_beat_cnt (wr_beat_cnt),
    .rd_beat_cnt (rd_beat_cnt),
    .proto_err   (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && amm.amm_readdatavalid_0 === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rdv: got readdatavalid=1 want 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("rd_data", amm.amm_readdata_0, mon_e.d);
        chk("rd_cycle", 256'(cyc), 256'(mon_e.c));
      end
    end
  end

  // Drives one beat, holds it until accepted; t is the accept cycle.
  task automatic beat(input logic rd, input logic wr, input logic [24:0] a,
                      input logic [255:0] d, input logic [31:0] be,
                      input logic [6:0] bc, output int t);
    int n;
    n = 0;
    amm.amm_read_0       = rd;
    amm.amm_write_0      = wr;
    amm.amm_address_0    = a;
    amm.amm_writedata_0  = d;
    amm.amm_byteenable_0 = be;
    amm.amm_burstcount_0 = bc;
    while (amm.amm_ready_0 !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_accept_timeout: got ready=0 want 1");
    end
    t = cyc;
    @(posedge clk); #1;
    amm.amm_read_0  = 1'b0;
    amm.amm_write_0 = 1'b0;
  endtask

  task automatic push_exp(input logic [255:0] d, input int c);
    exp_t e;
    e.d = d;
    e.c = c;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sb_drain", 256'(sb.size()), 256'd0);
  endtask

  initial begin
    int t;
    int seen;
    logic [31:0] wr0, rd0;
    logic [255:0] ones, a5, p55;
    ones = {256{1'b1}};
    a5   = {8{32'hA5A5A5A5}};
    p55  = {8{32'h55555555}};
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    amm.amm_read_0       = 1'b0;
    amm.amm_write_0      = 1'b0;
    amm.amm_address_0    = 25'd0;
    amm.amm_writedata_0  = 256'd0;
    amm.amm_byteenable_0 = 32'd0;
    amm.amm_burstcount_0 = 7'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_ready", 256'(amm.amm_ready_0), 256'd1);
    chk("rst_rdv", 256'(amm.amm_readdatavalid_0), 256'd0);
    chk("rst_rdata", amm.amm_readdata_0, 256'd0);
    chk("rst_wr_cnt", 256'(wr_beat_cnt), 256'd0);
    chk("rst_rd_cnt", 256'(rd_beat_cnt), 256'd0);
    chk("rst_perr", 256'(proto_err), 256'd0);
    idle(1);

    // Single write, then read in the very next cycle
    beat(1'b0, 1'b1, 25'h10, a5, 32'hFFFFFFFF, 7'd1, t);
    beat(1'b1, 1'b0, 25'h10, 256'd0, 32'd0, 7'd1, t);
    push_exp(a5, t + LAT);
    drain();
    idle(2);
    chk("rdata_hold", amm.amm_readdata_0, a5);

    // Byte-enable masking (burstcount 0 treated as 1)
    beat(1'b0, 1'b1, 25'h3, 256'd0, 32'hFFFFFFFF, 7'd0, t);
    beat(1'b0, 1'b1, 25'h3, ones, 32'h0000000F, 7'd1, t);
    beat(1'b1, 1'b0, 25'h3, 256'd0, 32'd0, 7'd1, t);
    push_exp({224'd0, 32'hFFFFFFFF}, t + LAT);
    drain();
    idle(1);

    // Write burst across the RAM top with a mid-burst gap
    wr0 = wr_beat_cnt;
    rd0 = rd_beat_cnt;
    beat(1'b0, 1'b1, 25'h3FE, 256'd1, 32'hFFFFFFFF, 7'd4, t);
    beat(1'b0, 1'b1, 25'h1ABCD, 256'd2, 32'hFFFFFFFF, 7'd9, t);
    idle(2);
    beat(1'b0, 1'b1, 25'h0, 256'd3, 32'hFFFFFFFF, 7'd1, t);
    beat(1'b0, 1'b1, 25'h0, 256'd4, 32'hFFFFFFFF, 7'd1, t);
    chk("wrb_ready_after", 256'(amm.amm_ready_0), 256'd1);
    beat(1'b1, 1'b0, 25'h3FE, 256'd0, 32'd0, 7'd4, t);
    for (int j = 0; j < 4; j++) push_exp(256'(j + 1), t + j + LAT);
    for (int j = 0; j < 3; j++) begin
      chk("rdb_ready_low", 256'(amm.amm_ready_0), 256'd0);
      idle(1);
    end
    chk("rdb_ready_back", 256'(amm.amm_ready_0), 256'd1);
    drain();
    idle(1);
    chk("wrb_wr_cnt", 256'(wr_beat_cnt - wr0), 256'd4);
    chk("rdb_rd_cnt", 256'(rd_beat_cnt - rd0), 256'd4);
    // Upper address bits alias: 0x7FF maps to word 0x3FF
    beat(1'b1, 1'b0, 25'h7FF, 256'd0, 32'd0, 7'd1, t);
    push_exp(256'd2, t + LAT);
    drain();
    idle(1);

    // Protocol violation: read & write together in IDLE
    chk("perr_before", 256'(proto_err), 256'd0);
    beat(1'b1, 1'b1, 25'h5, p55, 32'hFFFFFFFF, 7'd1, t);
    idle(LAT + 2);
    chk("perr_set", 256'(proto_err), 256'd1);
    beat(1'b1, 1'b0, 25'h5, 256'd0, 32'd0, 7'd1, t);
    push_exp(p55, t + LAT);
    drain();
    idle(5);
    chk("perr_sticky", 256'(proto_err), 256'd1);

    // Reset two cycles after a burst-8 read accept
    beat(1'b1, 1'b0, 25'h10, 256'd0, 32'd0, 7'd8, t);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("mrst_ready", 256'(amm.amm_ready_0), 256'd1);
    chk("mrst_perr", 256'(proto_err), 256'd0);
    seen = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (amm.amm_readdatavalid_0 !== 1'b0) seen++;
    end
    @(posedge clk); #1;
    chk("mrst_no_rdv", 256'(seen), 256'd0);
    chk("mrst_rd_cnt", 256'(rd_beat_cnt), 256'd0);
    chk("mrst_wr_cnt", 256'(wr_beat_cnt), 256'd0);
    chk("mrst_ready_idle", 256'(amm.amm_ready_0), 256'd1);
    chk("sb_empty_end", 256'(sb.size()), 256'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
